// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N level requesters; one registered one-hot grant held until done (optional RR_ARBITER_LOCK_EN adds lock).
// Latency: grant registered on the edge that samples req (IDLE) or done (BUSY), so back-to-back grants have no gap.
// Backpressure: the owner keeps the grant until done; req changes never revoke it.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SIZE = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
`ifdef RR_ARBITER_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    gnt,
    output logic [SIZE-1:0] gnt_idx,
    output logic            gnt_valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   ptr_q, ptr_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [SIZE-1:0]   gnt_idx_q, gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;

    logic              win_vld;
    logic [SIZE-1:0]   win_idx;
    logic              keep;
    logic              rearb;
    int                k;
    int                win_nxt;

    // Walk from the farthest offset back to ptr so the nearest requester is written last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        k       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr_q) + i;
            if (k >= N) k = k - N;
            if (req[k[SIZE-1:0]]) begin
                win_vld = 1'b1;
                win_idx = k[SIZE-1:0];
            end
        end
        win_nxt = int'(win_idx) + 1;
        if (win_nxt >= N) win_nxt = 0;
    end

`ifdef RR_ARBITER_LOCK_EN
    assign keep = lock && req[gnt_idx_q];
`else
    assign keep = 1'b0;
`endif

    assign rearb = (state_q == IDLE) || (done && !keep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = BUSY;
            BUSY:    if (rearb && !win_vld) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        if (rearb) begin
            if (win_vld) begin
                gnt_d          = '0;
                gnt_d[win_idx] = 1'b1;
                gnt_idx_d      = win_idx;
                gnt_valid_d    = 1'b1;
                ptr_d          = SIZE'(win_nxt);
            end else begin
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_in_known:    assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({req, done}));
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomized and directed bench for rr_arbiter (N=4) against a modular-arithmetic reference model.
module tb_rr_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic         lock;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;

    int n_checks;
    int n_pass;
    int own;
    int mptr;

    rr_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
`ifdef RR_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: owner -1 means idle; a new owner is picked whenever idle or released.
    task automatic model_step(input logic [N-1:0] r, input logic d, input logic l);
        int w;
        w = -1;
        if (own >= 0 && !d) return;
`ifdef RR_ARBITER_LOCK_EN
        if (own >= 0 && d && l && r[own]) return;
`endif
        for (int off = 0; off < N; off++)
            if (w < 0 && r[(mptr + off) % N]) w = (mptr + off) % N;
        if (w >= 0) begin
            own  = w;
            mptr = (w + 1) % N;
        end else begin
            own = -1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".gnt"},   32'(gnt),       (own < 0) ? 32'd0 : (32'd1 << own));
        check({tag, ".idx"},   32'(gnt_idx),   (own < 0) ? 32'd0 : 32'(own));
        check({tag, ".valid"}, 32'(gnt_valid), (own < 0) ? 32'd0 : 32'd1);
    endtask

    task automatic step(input logic [N-1:0] r, input logic d, input logic l, input string tag);
        @(negedge clk);
        req  = r;
        done = d;
        lock = l;
        model_step(r, d, l);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        done  = 1'b0;
        lock  = 1'b0;
        rst_n = 1'b0;
        own   = -1;
        mptr  = 0;
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        own      = -1;
        mptr     = 0;
        rst_n    = 1'b0;
        req      = '0;
        done     = 1'b0;
        lock     = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // First grant, then wrap-and-skip from ptr=3 to requester 1.
        step(4'b0100, 1'b0, 1'b0, "first");
        check("first_idx_const", 32'(gnt_idx), 32'd2);
        step(4'b0010, 1'b1, 1'b0, "wrap");
        check("wrap_idx_const", 32'(gnt_idx), 32'd1);
        // ptr now 2: with all requesting, next owner must be 2.
        step(4'b1111, 1'b1, 1'b0, "wrap_ptr");
        check("wrap_ptr_const", 32'(gnt_idx), 32'd2);

        // Fairness from reset: 0,1,2,3,0,1 with done every cycle.
        do_reset();
        step(4'b1111, 1'b0, 1'b0, "fair0");
        check("fair_seq0", 32'(gnt_idx), 32'd0);
        for (int i = 1; i < 6; i++) begin
            step(4'b1111, 1'b1, 1'b0, "fair");
            check("fair_seq", 32'(gnt_idx), 32'(i % N));
        end

        // Hold: owner 2 drops req, no done for 10 cycles.
        do_reset();
        step(4'b0100, 1'b0, 1'b0, "hold_acq");
        for (int i = 0; i < 10; i++) begin
            step(4'b1011, 1'b0, 1'b0, "hold");
            check("hold_gnt_const", 32'(gnt), 32'h4);
        end
        step(4'b1011, 1'b1, 1'b0, "hold_rel");
        check("hold_rel_const", 32'(gnt_idx), 32'd3);

        // Drain to idle, done in idle ignored, then async reset mid-grant.
        step(4'b0000, 1'b1, 1'b0, "drain");
        check("drain_gnt_const", 32'(gnt), 32'd0);
        step(4'b0000, 1'b1, 1'b0, "idle_done");
        step(4'b0001, 1'b0, 1'b0, "reacq");
        #3;
        rst_n = 1'b0;
        own   = -1;
        mptr  = 0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RR_ARBITER_LOCK_EN
        do_reset();
        step(4'b0010, 1'b0, 1'b0, "lock_acq");
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1, 1'b1, "lock_hold");
            check("lock_hold_const", 32'(gnt_idx), 32'd1);
        end
        step(4'b1111, 1'b1, 1'b0, "lock_rel");
        check("lock_rel_const", 32'(gnt_idx), 32'd2);
        // Locking an owner without req re-arbitrates normally.
        step(4'b1011, 1'b1, 1'b1, "lock_noreq");
        check("lock_noreq_const", 32'(gnt_idx), 32'd3);
`endif

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            logic         d;
            logic         l;
            r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            d = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 3) == 0);
`ifndef RR_ARBITER_LOCK_EN
            l = 1'b0;
`endif
            step(r, d, l, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
